instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Instruction fetch and sequencing unit for the single-cycle 9-bit custom ISA.
- Owns the PC, splits the fetched word into opcode, f and raddr fields for the control decoder, and consumes the decoder's halt_ctrl, j, br_ne and br_lt outputs to select the next PC.
- Implements the start/done handshake with the testbench and counts executed instructions.

Parameters:
- PC_W, 10, PC and instruction-ROM address width.
- INSTR_W, 9, instruction width; the field layout below is fixed for 9.
- LUT_DEPTH, 32, number of entries in the branch/jump target LUT.
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  testbench start; held high to load, released to run.
- start_addr  in  PC_W  PC loaded while start is high.
- instr_in  in  INSTR_W  instruction ROM data at pc_out (combinational ROM).
- halt_ctrl  in  1  decoder: SUS instruction.
- j  in  1  decoder: unconditional jump.
- br_ne  in  1  decoder: BNE instruction.
- br_lt  in  1  decoder: BLT instruction.
- ne_flag  in  1  datapath: compared values not equal.
- lt_flag  in  1  datapath: LT register value.
- pc_out  out  PC_W  current PC, drives ROM address.
- opcode  out  4  instr_in[8:5].
- f  out  1  instr_in[4].
- raddr1  out  4  instr_in[3:0].
- exec_en  out  1  high only in RUN; datapath gates all register, memory and flag writes with it.
- done  out  1  program halted.
- instr_cnt  out  CNT_W  instructions retired since the last start.

Behaviour:
- Reset: state=IDLE, pc_out=0, done=0, instr_cnt=0, exec_en=0. Field outputs remain combinational from instr_in.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: every cycle pc<=start_addr, instr_cnt<=0, done<=0. start=0 -> RUN.
  - RUN: executes one instruction per cycle (see next-PC rules).
  - HALT: done=1; pc and instr_cnt frozen. start=1 -> LOAD.
- start=1 in RUN aborts the program: -> LOAD on the next edge, same as a restart. Nothing is retired that cycle.
- Next-PC priority in RUN, evaluated on the current cycle's decoder outputs:
  1. halt_ctrl: pc holds; -> HALT; the SUS is counted in instr_cnt; done=1 from the next cycle.
  2. j: pc <= LUT[instr_in[4:0]].
  3. (br_ne & ne_flag) | (br_lt & lt_flag): pc <= LUT[instr_in[4:0]].
  4. Otherwise: pc <= pc+1, wrapping modulo 2^PC_W (max -> 0, no flag).
- Simultaneous j and branch: j wins. halt_ctrl with any other request: halt wins.
- A branch whose flag is false falls through to pc+1.
- instr_cnt increments by 1 on every RUN cycle that is not aborted by start, and saturates at all-ones.
- Latency: the redirect takes effect on the next edge; there are no delay slots or bubbles.
- The LUT index is always 5 bits. When LUT_DEPTH<32, out-of-range indices return 0.
- done falls only on entry to LOAD or on reset.
- Reset mid-RUN: immediate return to the reset values listed above.

Decomposition:
- Shared package isa_pkg:
  - opcode constants: OP_ADDI=4'b0000, OP_BNE=4'b0001, OP_BLT=4'b0010, OP_J=4'b0110, OP_SUS=4'b1111 with f=1.
  - field position localparams.
  - the fetch state enum {IDLE, LOAD, RUN, HALT}.
  - the constant target-LUT array.
- Sub-module branch_lut: combinational, 5-bit index in, PC_W target out, contents from isa_pkg.

Test Plan:
1. Reset, then start=1 for 3 cycles with start_addr=10'd5, then start=0 -> pc_out=5 during LOAD. With the ROM giving non-control instructions, pc_out=6,7,8 on successive cycles, exec_en=1, instr_cnt=3 after 3 RUN cycles.
2. Jump: j=1, instr_in[4:0]=5'd3, LUT[3]=10'd40 -> pc_out=40 on the next cycle. j=1 and br_ne=1 with ne_flag=1 in the same cycle -> still 40.
3. Branches:
   - br_ne=1, ne_flag=0 -> pc+1.
   - br_ne=1, ne_flag=1 -> LUT target.
   - br_lt=1, lt_flag=1, index 5'd7 (LUT[7]=10'd100) -> pc_out=100.
4. Halt: halt_ctrl=1 at pc=12 -> done=1 next cycle, pc_out stays 12, exec_en=0, instr_cnt frozen. A second start with start_addr=0 -> done=0 in LOAD, instr_cnt=0.
5. Wrap and saturation:
   - pc=10'h3FF with a non-control instruction -> pc_out=0.
   - instr_cnt forced near 16'hFFFF -> holds at 16'hFFFF.
6. Asynchronous reset asserted mid-RUN, between clock edges -> pc_out=0, done=0, instr_cnt=0 immediately; after release the state stays IDLE until start.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared constants for the 9-bit custom ISA: opcodes,
//                instruction field positions, fetch state encoding and the
//                constant branch/jump target table.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    // Opcodes (instr[8:5]); SUS is only a halt when f=1
    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_BNE  = 4'b0001;
    localparam logic [3:0] OP_BLT  = 4'b0010;
    localparam logic [3:0] OP_J    = 4'b0110;
    localparam logic [3:0] OP_SUS  = 4'b1111;
    localparam logic       SUS_F   = 1'b1;

    // Field positions of the fixed 9-bit layout
    localparam int OPC_MSB     = 8;
    localparam int OPC_LSB     = 5;
    localparam int F_BIT       = 4;
    localparam int RADDR_MSB   = 3;
    localparam int LUT_IDX_MSB = 4;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    // Branch/jump targets, indexed by instr[4:0]; entry i = (15*i - 5) mod 1024
    localparam int LUT_ENTRIES = 32;
    localparam logic [9:0] TARGET_LUT [LUT_ENTRIES] = '{
        10'd1019, 10'd10,  10'd25,  10'd40,  10'd55,  10'd70,  10'd85,  10'd100,
        10'd115,  10'd130, 10'd145, 10'd160, 10'd175, 10'd190, 10'd205, 10'd220,
        10'd235,  10'd250, 10'd265, 10'd280, 10'd295, 10'd310, 10'd325, 10'd340,
        10'd355,  10'd370, 10'd385, 10'd400, 10'd415, 10'd430, 10'd445, 10'd460
    };

endpackage
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
//  Module      : branch_lut
//  Description : Combinational branch/jump target table. Indices at or beyond
//                LUT_DEPTH read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_lut
    import isa_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32
) (
    input  logic [4:0]      idx_i,
    output logic [PC_W-1:0] target_o
);

    // Table read with out-of-range entries masked to zero
    always_comb begin
        target_o = '0;
        if (int'(idx_i) < LUT_DEPTH) begin
            target_o = PC_W'(TARGET_LUT[idx_i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_seq
//  Description : PC owner and fetch sequencer. Splits the fetched word into
//                decoder fields, selects the next PC from the decoder's
//                halt/jump/branch outputs, runs the start/done handshake and
//                counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_seq
    import isa_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 32,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               halt_ctrl,
    input  logic               j,
    input  logic               br_ne,
    input  logic               br_lt,
    input  logic               ne_flag,
    input  logic               lt_flag,
    output logic [PC_W-1:0]    pc_out,
    output logic [3:0]         opcode,
    output logic               f,
    output logic [3:0]         raddr1,
    output logic               exec_en,
    output logic               done,
    output logic [CNT_W-1:0]   instr_cnt
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  lut_target;
    logic             take_branch;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_branch_lut (
        .idx_i    (instr_in[LUT_IDX_MSB:0]),
        .target_o (lut_target)
    );

    assign opcode      = instr_in[OPC_MSB:OPC_LSB];
    assign f           = instr_in[F_BIT];
    assign raddr1      = instr_in[RADDR_MSB:0];
    assign take_branch = (br_ne & ne_flag) | (br_lt & lt_flag);
    assign exec_en     = (state_q == ST_RUN);
    assign pc_out      = pc_q;
    assign done        = done_q;
    assign instr_cnt   = cnt_q;

    // Next-state/PC selection. Any cycle that ends in LOAD (start from any
    // state) or leaves LOAD reloads the PC and clears done and the counter,
    // so an abort from RUN behaves exactly like a restart.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (start || (state_q == ST_LOAD)) begin
            pc_d    = start_addr;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = start ? ST_LOAD : ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (halt_ctrl) begin
                state_d = ST_HALT;
                done_d  = 1'b1;
            end else if (j || take_branch) begin
                pc_d = lut_target;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_seq
//  Description : Scoreboard bench for instr_fetch_seq. Each cycle the driver
//                pushes the reference model's expected outputs; a monitor on
//                the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_seq;

    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, halt_ctrl, j, br_ne, br_lt, ne_flag, lt_flag;
    logic [9:0] start_addr;
    logic [8:0] instr_in;
    logic [9:0] pc_out;
    logic [3:0] opcode, raddr1;
    logic       f, exec_en, done;
    logic [15:0] instr_cnt;

    always #5 clk = ~clk;

    instr_fetch_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .instr_in   (instr_in),
        .halt_ctrl  (halt_ctrl),
        .j          (j),
        .br_ne      (br_ne),
        .br_lt      (br_lt),
        .ne_flag    (ne_flag),
        .lt_flag    (lt_flag),
        .pc_out     (pc_out),
        .opcode     (opcode),
        .f          (f),
        .raddr1     (raddr1),
        .exec_en    (exec_en),
        .done       (done),
        .instr_cnt  (instr_cnt)
    );

    typedef struct {
        logic [9:0]  pc;
        logic        dn;
        logic        en;
        logic [15:0] cnt;
        logic [3:0]  opc;
        logic        fb;
        logic [3:0]  ra;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: architectural state after the most recent edge
    int          m_st;
    int          m_pc;
    int          m_cnt;
    logic        m_done;

    function automatic int lut_ref(input int idx);
        return (15 * idx + 1019) % 1024;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_pc = 0; m_cnt = 0; m_done = 1'b0;
    endtask

    // One clock cycle of stimulus: drive, record expectation, advance model
    task automatic step(input logic s_rst_n, input logic s_start, input logic [9:0] s_addr,
                        input logic [8:0] s_instr, input logic s_halt, input logic s_j,
                        input logic s_bne, input logic s_blt, input logic s_ne,
                        input logic s_lt, input logic s_force);
        exp_t e;
        @(posedge clk);
        #1;
        if (s_force) begin
            force dut.cnt_q = 16'hFFFD;
            #1;
            release dut.cnt_q;
            m_cnt = 16'hFFFD;
        end
        rst_n = s_rst_n;
        if (!s_rst_n) model_reset();
        start = s_start; start_addr = s_addr; instr_in = s_instr;
        halt_ctrl = s_halt; j = s_j; br_ne = s_bne; br_lt = s_blt;
        ne_flag = s_ne; lt_flag = s_lt;
        e.pc = 10'(m_pc); e.dn = m_done; e.en = (m_st == M_RUN); e.cnt = 16'(m_cnt);
        e.opc = s_instr[8:5]; e.fb = s_instr[4]; e.ra = s_instr[3:0];
        q.push_back(e);
        if (s_rst_n) begin
            if (s_start) begin
                m_st = M_LOAD; m_pc = int'(s_addr); m_cnt = 0; m_done = 1'b0;
            end else if (m_st == M_IDLE || m_st == M_HALT) begin
                // idle or halted: nothing moves
            end else if (m_st == M_LOAD) begin
                m_st = M_RUN; m_pc = int'(s_addr); m_cnt = 0; m_done = 1'b0;
            end else begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (s_halt) begin
                    m_st = M_HALT; m_done = 1'b1;
                end else if (s_j || (s_bne && s_ne) || (s_blt && s_lt)) begin
                    m_pc = lut_ref(int'(s_instr[4:0]));
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end
    endtask

    // Non-control instruction in RUN (ADDI with random operands)
    task automatic nc();
        logic [4:0] r;
        r = 5'($urandom);
        step(1'b1, 1'b0, 10'd0, {4'b0000, r}, 1'b0, 1'b0, 1'b0, 1'b0,
             1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest outstanding expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            chk("pc_out",    int'(pc_out),    int'(e.pc));
            chk("done",      int'(done),      int'(e.dn));
            chk("exec_en",   int'(exec_en),   int'(e.en));
            chk("instr_cnt", int'(instr_cnt), int'(e.cnt));
            chk("opcode",    int'(opcode),    int'(e.opc));
            chk("f",         int'(f),         int'(e.fb));
            chk("raddr1",    int'(raddr1),    int'(e.ra));
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; instr_in = '0;
        halt_ctrl = 1'b0; j = 1'b0; br_ne = 1'b0; br_lt = 1'b0;
        ne_flag = 1'b0; lt_flag = 1'b0;
        model_reset();

        // Reset, then idle without start
        step(1'b0, 1'b0, 10'd0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 9'h15A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd9, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd9, 9'h1C4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load at 5 for three cycles, run three sequential instructions
        repeat (3) step(1'b1, 1'b1, 10'd5, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd5, 9'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) nc();

        // Jump to LUT[3]=40, then jump+taken BNE together
        step(1'b1, 1'b0, 10'd0, {4'b0110, 5'd3}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd0, {4'b0110, 5'd3}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Branches: not-taken BNE, taken BNE, taken BLT to LUT[7]=100, not-taken BLT
        step(1'b1, 1'b0, 10'd0, {4'b0001, 5'd9}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'd0, {4'b0001, 5'd9}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd0, {4'b0010, 5'd7}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'd0, {4'b0010, 5'd7}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        nc();

        // Halt at pc=12 (halt beats a simultaneous jump), sit in HALT, restart at 0
        step(1'b1, 1'b1, 10'd12, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd12, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nc();
        step(1'b1, 1'b0, 10'd0, 9'h1F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 10'd12, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd12, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd0, {4'b1111, 1'b1, 4'd0}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 10'd0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nc();

        // PC wrap 0x3FE -> 0x3FF -> 0
        step(1'b1, 1'b1, 10'h3FE, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'h3FE, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) nc();

        // Counter saturation from 0xFFFD
        step(1'b1, 1'b0, 10'd0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) nc();

        // Asynchronous reset mid-RUN, then stay idle without start
        step(1'b0, 1'b0, 10'd0, 9'h012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 9'h013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 10'd77, 9'h014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic: occasional restarts, halts, jumps, branches
        for (int i = 0; i < 600; i++) begin
            logic       r_start;
            logic [9:0] r_addr;
            r_start = ($urandom_range(0, 24) == 0) || (m_st == M_HALT && $urandom_range(0, 3) == 0);
            r_addr  = ($urandom_range(0, 3) == 0) ? 10'(10'h3F8 + $urandom_range(0, 7)) : 10'($urandom);
            step(1'b1, r_start, r_addr, 9'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        // Drain outstanding expectations within a bounded number of cycles
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
